// File: rtl/seg7_pkg.sv
// Shared types and constants for the registered hex to 7-segment decoder.
// Segment vectors are ordered {A,B,C,D,E,F,G}; 1 means the segment is lit.
package seg7_pkg;

  localparam int NIBBLE_W = 4;
  localparam int SEG_W    = 7;

  typedef logic [SEG_W-1:0]    seg_vec_t;
  typedef logic [NIBBLE_W-1:0] nibble_t;

  // Combined LUT result: logical segment pattern plus the A-F flag.
  typedef struct packed {
    seg_vec_t seg;
    logic     alpha;
  } lut_out_t;

  localparam seg_vec_t SEG_BLANK     = '0;
  localparam nibble_t  HEX_ALPHA_MIN = 4'd10;

  localparam seg_vec_t HEX_PATTERNS [16] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000,  // 7
    7'b1111111,  // 8
    7'b1111011,  // 9
    7'b1110111,  // A
    7'b0011111,  // b
    7'b1001110,  // C
    7'b0111101,  // d
    7'b1001111,  // E
    7'b1000111   // F
  };

  function automatic lut_out_t hex_decode(input nibble_t n);
    lut_out_t r;
    r.seg   = HEX_PATTERNS[n];
    r.alpha = (n >= HEX_ALPHA_MIN);
    return r;
  endfunction

endpackage

// File: rtl/seg7_lut.sv
// Purely combinational nibble -> {logical segments, alpha flag} lookup.
module seg7_lut
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg,
  output logic       alpha
);

  lut_out_t dec;

  always_comb begin
    dec   = hex_decode(nibble);
    seg   = dec.seg;
    alpha = dec.alpha;
  end

endmodule

// File: rtl/seg7_hex_decoder.sv
// Registered hex to 7-segment decoder for one display digit; every output
// comes straight from a flop, so a-d never reach the pins combinationally.
module seg7_hex_decoder
  import seg7_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW   = 1'b0,
  parameter bit DIGIT_ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic A,
  output logic B,
  output logic C,
  output logic D,
  output logic E,
  output logic F,
  output logic G,
  output logic Dp,
  output logic digit
);

  localparam seg_vec_t SEG_INV   = {SEG_W{SEG_ACTIVE_LOW}};
  localparam seg_vec_t SEG_OFF   = SEG_BLANK ^ SEG_INV;
  localparam logic     DP_OFF    = SEG_ACTIVE_LOW;
  localparam logic     DIGIT_OFF = DIGIT_ACTIVE_LOW;
  localparam logic     DIGIT_ON  = ~DIGIT_ACTIVE_LOW;

  logic [3:0] nibble;
  logic [6:0] lut_seg;
  logic       lut_alpha;

  seg_vec_t   seg_d, seg_q;
  logic       dp_d, dp_q;
  logic       digit_d, digit_q;

  assign nibble = {a, b, c, d};

  seg7_lut u_lut (
    .nibble (nibble),
    .seg    (lut_seg),
    .alpha  (lut_alpha)
  );

  // Polarity is applied after decoding so the table stays in logical form.
  always_comb begin
    seg_d   = lut_seg ^ SEG_INV;
    dp_d    = lut_alpha ^ SEG_ACTIVE_LOW;
    digit_d = DIGIT_ON;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q   <= SEG_OFF;
      dp_q    <= DP_OFF;
      digit_q <= DIGIT_OFF;
    end else begin
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      digit_q <= digit_d;
    end
  end

  assign {A, B, C, D, E, F, G} = seg_q;
  assign Dp    = dp_q;
  assign digit = digit_q;

endmodule

// File: tb/tb_seg7_hex_decoder.sv
// Directed + randomized bench for seg7_hex_decoder against a letter-table model.
module tb_seg7_hex_decoder;

  logic clk, rst, a, b, c, d;
  logic [6:0] p_seg, n_seg;
  logic       p_dp, n_dp, p_dig, n_dig;

  int tests = 0;
  int fails = 0;

  seg7_hex_decoder #(.SEG_ACTIVE_LOW(1'b0), .DIGIT_ACTIVE_LOW(1'b0)) u_pos (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
    .A(p_seg[6]), .B(p_seg[5]), .C(p_seg[4]), .D(p_seg[3]),
    .E(p_seg[2]), .F(p_seg[1]), .G(p_seg[0]), .Dp(p_dp), .digit(p_dig)
  );

  seg7_hex_decoder #(.SEG_ACTIVE_LOW(1'b1), .DIGIT_ACTIVE_LOW(1'b1)) u_neg (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
    .A(n_seg[6]), .B(n_seg[5]), .C(n_seg[4]), .D(n_seg[3]),
    .E(n_seg[2]), .F(n_seg[1]), .G(n_seg[0]), .Dp(n_dp), .digit(n_dig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lit segments per hex digit, written as letters.
  string lit_tab [16] = '{"ABCDEF", "BC", "ABDEG", "ABCDG", "BCFG", "ACDFG",
                          "ACDEFG", "ABC", "ABCDEFG", "ABCDFG", "ABCEFG",
                          "CDEFG", "ADEF", "BCDEG", "ADEFG", "AEFG"};

  // Expected {A..G, Dp, digit} for nibble n; active=0 means blanked (reset).
  function automatic logic [8:0] model(input int n, input bit seg_lo,
                                       input bit dig_lo, input bit active);
    string names;
    string lit;
    logic [8:0] v;
    names = "ABCDEFG";
    lit   = lit_tab[n];
    v     = '0;
    if (active) begin
      for (int i = 0; i < 7; i++)
        for (int j = 0; j < lit.len(); j++)
          if (lit[j] == names[i]) v[8-i] = 1'b1;
      v[1] = (n >= 10);
      v[0] = 1'b1;
    end
    for (int i = 1; i < 9; i++) v[i] = v[i] ^ seg_lo;
    v[0] = v[0] ^ dig_lo;
    return v;
  endfunction

  task automatic chk(input string tag, input int n, input bit active);
    logic [8:0] obs, exp;
    obs = {p_seg, p_dp, p_dig};
    exp = model(n, 1'b0, 1'b0, active);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s pos n=%0d observed=%b expected=%b", tag, n, obs, exp);
    end
    obs = {n_seg, n_dp, n_dig};
    exp = model(n, 1'b1, 1'b1, active);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s neg n=%0d observed=%b expected=%b", tag, n, obs, exp);
    end
  endtask

  task automatic set_nib(input int n);
    {a, b, c, d} = 4'(n);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic [3:0] smp;
    rst = 1'b1;
    set_nib(0);
    #1 chk("reset_initial", 0, 1'b0);

    // Release mid-cycle with nibble 0 applied.
    @(negedge clk); rst = 1'b0;
    tick(); chk("first_after_reset", 0, 1'b1);

    // Full sweep, one value per clock.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); set_nib(i);
      tick(); chk("sweep", i, 1'b1);
    end

    // Async reset mid-cycle must blank before any edge.
    #2 rst = 1'b1;
    #1 chk("async_reset", 0, 1'b0);
    tick(); chk("held_reset", 0, 1'b0);
    @(negedge clk); rst = 1'b0; set_nib(5);
    tick(); chk("resume", 5, 1'b1);

    // Glitch 1->7->1 between edges is invisible.
    @(negedge clk); set_nib(1);
    tick(); chk("glitch_pre", 1, 1'b1);
    #1 set_nib(7);
    #2 set_nib(1);
    #2 chk("glitch_mid", 1, 1'b1);
    tick(); chk("glitch_post", 1, 1'b1);

    // Reset during activity with nibble F.
    @(negedge clk); set_nib(15);
    tick(); chk("f_before_rst", 15, 1'b1);
    #2 rst = 1'b1;
    #1 chk("f_rst_blank", 15, 1'b0);
    @(negedge clk); rst = 1'b0;
    tick(); chk("f_after_rst", 15, 1'b1);

    // Randomized nibbles, some changed twice before the edge.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      set_nib(int'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 1) begin
        #2 n = int'($urandom_range(0, 15)); set_nib(n);
      end
      @(posedge clk); smp = {a, b, c, d};
      #1 chk("random", int'(smp), 1'b1);
    end

    // Independent-period toggling, offset from the clock edges.
    @(posedge clk); #2;
    fork
      repeat (33) #30  a = ~a;
      repeat (20) #50  b = ~b;
      repeat (13) #75  c = ~c;
      repeat (10) #100 d = ~d;
      repeat (100) begin
        @(posedge clk); smp = {a, b, c, d};
        #1 chk("async_early", int'(smp), 1'b1);
        #7 chk("async_late", int'(smp), 1'b1);
      end
    join

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
